// File: rtl/wrdata_aligner_if.sv
// Write-request / aligned-word handshake bundle for wrdata_aligner.
// The slave modport is the aligner's view; master is the upstream/downstream driver view.
interface wrdata_aligner_if #(
    parameter int ADDR_W = 15
);
    logic              bist_active_i;
    logic [2:0]        input_config_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [ADDR_W-1:0] addr_i;
    logic [19:0]       wrdata_i;
    logic [19:0]       bitmask_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [ADDR_W-1:0] word_addr_o;
    logic [19:0]       aligned_wrdata_o;
    logic [19:0]       aligned_bitmask_o;
    logic              cfg_err_o;

    modport slave (
        input  bist_active_i, input_config_i, in_valid_i, addr_i, wrdata_i, bitmask_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, word_addr_o, aligned_wrdata_o, aligned_bitmask_o,
        output cfg_err_o
    );

    modport master (
        output bist_active_i, input_config_i, in_valid_i, addr_i, wrdata_i, bitmask_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, word_addr_o, aligned_wrdata_o, aligned_bitmask_o,
        input  cfg_err_o
    );
endinterface

// File: rtl/wrdata_aligner.sv
// Places narrow writes into their lane of the 20-bit physical word and buffers the result
// in an output register plus one skid register (full throughput, registered in_ready).
module wrdata_aligner #(
    parameter int         ADDR_W       = 15,
    parameter logic [2:0] CONFIG_1BIT  = 3'd1,
    parameter logic [2:0] CONFIG_2BIT  = 3'd2,
    parameter logic [2:0] CONFIG_5BIT  = 3'd3,
    parameter logic [2:0] CONFIG_10BIT = 3'd4,
    parameter logic [2:0] CONFIG_20BIT = 3'd5,
    parameter logic [2:0] CONFIG_40BIT = 3'd6,
    parameter logic [2:0] CONFIG_80BIT = 3'd7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wrdata_aligner_if.slave  bus
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [19:0]       data;
        logic [19:0]       mask;
    } entry_t;

    entry_t      new_entry;
    entry_t      out_q, out_d, skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        cfg_err_q, cfg_err_d;

    logic        narrow, cfg_bad;
    logic [4:0]  width;
    logic [2:0]  shift;
    logic [3:0]  slot;
    logic [4:0]  pos;
    logic [19:0] lane_mask;
    logic        accept, enq, drain;

    // NOTE: every signal assigned in a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin : align
        narrow  = 1'b0;
        cfg_bad = 1'b0;
        width   = 5'd20;
        shift   = 3'd0;
        if (!bus.bist_active_i) begin
            unique case (bus.input_config_i)
                CONFIG_1BIT:  begin narrow = 1'b1; width = 5'd1;  shift = 3'd4; end
                CONFIG_2BIT:  begin narrow = 1'b1; width = 5'd2;  shift = 3'd3; end
                CONFIG_5BIT:  begin narrow = 1'b1; width = 5'd5;  shift = 3'd2; end
                CONFIG_10BIT: begin narrow = 1'b1; width = 5'd10; shift = 3'd1; end
                CONFIG_20BIT, CONFIG_40BIT, CONFIG_80BIT: narrow = 1'b0;
                default:      cfg_bad = 1'b1;
            endcase
        end

        slot      = bus.addr_i[3:0] & ~(4'hF << shift);
        pos       = {1'b0, slot} * width;
        lane_mask = ~(20'hFFFFF << width);

        new_entry.addr = bus.addr_i >> shift;
        new_entry.data = bus.wrdata_i;
        new_entry.mask = bus.bitmask_i;
        if (narrow) begin
            new_entry.data = (bus.wrdata_i & lane_mask) << pos;
            new_entry.mask = (bus.bitmask_i & lane_mask) << pos;
        end
    end

    // Skid is only ever filled while the output register holds a word that is not leaving.
    always_comb begin : buffer
        accept       = bus.in_valid_i && in_ready_q;
        enq          = accept && !cfg_bad;
        drain        = out_valid_q && bus.out_ready_i;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (enq) begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (enq) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end

        in_ready_d = !skid_valid_d;
        cfg_err_d  = accept && cfg_bad;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.in_ready_o        = in_ready_q;
    assign bus.out_valid_o       = out_valid_q;
    assign bus.word_addr_o       = out_q.addr;
    assign bus.aligned_wrdata_o  = out_q.data;
    assign bus.aligned_bitmask_o = out_q.mask;
    assign bus.cfg_err_o         = cfg_err_q;

endmodule
